alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the LC-3b datapath. Adds LC-3b shifts (LSHF/RSHFL/RSHFA),
//  an optional iterative multiply and NZP/overflow flags to ADD/AND/XOR/PASSA.
//  Uses a valid/ready handshake so the control FSM can stall on multi-cycle ops.
//  Sits between the register-file/SR2MUX operands and the bus/CC logic.
// PARAMETERS
//  WIDTH     16                    operand/result width, >=4
//  SHAMT_W   $clog2(WIDTH)         bits of B used as the shift amount
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  in_valid   in   1        operands/op presented
//  in_ready   out  1        unit can accept an op
//  op         in   3        operation code (see BEHAVIOUR)
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B / shift amount in b[SHAMT_W-1:0]
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer accepts result
//  result     out  WIDTH    registered result
//  nzp        out  3        {N,Z,P} of result; exactly one bit set when out_valid
//  ovf        out  1        signed overflow (ADD only, else 0)
//  illegal    out  1        op unsupported in this build
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; nzp=3'b010; ovf=0; illegal=0.
//  - Ops: 000 ADD, 001 AND, 010 XOR, 011 PASSA, 100 LSHF, 101 RSHFL (zero fill), 110 RSHFA (sign fill),
//    111 MUL (low WIDTH bits of a*b). ADD wraps mod 2^WIDTH; ovf=(a[MSB]==b[MSB])&&(res[MSB]!=a[MSB]).
//  - States IDLE, BUSY, DONE. in_ready = (state==IDLE). Accept = in_valid && in_ready; op/a/b captured.
//  - IDLE->DONE on accept of ADD/AND/XOR/PASSA, or shift with amount 0: out_valid 1 cycle after accept.
//  - IDLE->BUSY on accept of shift with amount k>0: one bit position per cycle; out_valid k+1 cycles after accept.
//  - IDLE->BUSY on accept of MUL: shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY;
//    out_valid WIDTH+1 cycles after accept.
//  - BUSY->DONE when iteration counter reaches 0; result/nzp/ovf/illegal update on that edge only.
//  - DONE: outputs held stable while out_valid && !out_ready. DONE->IDLE on out_ready; in_ready rises the next
//    cycle (no same-cycle back-to-back accept). Outputs keep last value after handshake; only out_valid drops.
//  - Inputs ignored when in_ready=0; changes to a/b/op after accept have no effect.
//  - Shift amount uses b[SHAMT_W-1:0] only; upper bits ignored. Amount >= WIDTH impossible when WIDTH is a power of 2;
//    otherwise amount is saturated at WIDTH (LSHF/RSHFL give 0, RSHFA gives all sign bits), taking WIDTH cycles.
//  - nzp: N=result[WIDTH-1]; Z=(result==0); P=!N&&!Z.
//  - Reset mid-BUSY or mid-DONE aborts the op; the result is discarded and never presented.
// CONFIGURATION
//  ALU_MC_MUL_EN defined: op 111 runs the iterative multiplier as above; illegal=0 for all ops.
//  Not defined: no multiplier hardware; op 111 goes IDLE->DONE with 1-cycle latency, result=0, nzp=010,
//  ovf=0, illegal=1. All other ops are unaffected in both builds.
// STRUCTURE
//  Package alu_mc_pkg: op enum (ALU_ADD..ALU_MUL, 3 bits), state enum (S_IDLE,S_BUSY,S_DONE),
//  nzp constants (NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001).
//  Sub-module alu_mc_iter: iterative shift/multiply datapath (step enable, counter, done); MUL logic inside
//  `ifdef ALU_MC_MUL_EN. Top holds the FSM, handshake, single-cycle ops and flag/output registers.
// TESTING (WIDTH=16)
//  1. ADD a=16'h7FFF b=16'h0001, out_ready=1 -> out_valid 1 cycle after accept, result=16'h8000, nzp=100, ovf=1.
//  2. RSHFA a=16'h8010 b=16'h0004 -> out_valid 5 cycles after accept, result=16'hF801, nzp=100;
//     RSHFL same operands -> 16'h0801, nzp=001; LSHF b=0 -> 1-cycle latency, result=a.
//  3. Backpressure: AND a=16'h00F0 b=16'h0F00, out_ready=0 for 6 cycles -> result=0, nzp=010 held stable,
//     in_ready=0 throughout; in_valid pulses during the stall are ignored; out_ready=1 -> in_ready=1 next cycle.
//  4. MUL (ALU_MC_MUL_EN) a=16'd300 b=16'd300 -> out_valid 17 cycles after accept, result=16'h5F90, illegal=0;
//     without the macro -> 1 cycle after accept, result=0, illegal=1.
//  5. Assert reset 3 cycles into LSHF b=15 -> immediately out_valid=0, in_ready=1, result=0, nzp=010;
//     after reset release XOR a=16'hAAAA b=16'hFFFF -> result=16'h5555, nzp=001.
//  6. b=16'hFFF3 with LSHF a=16'h0001 -> amount 3, result=16'h0008, out_valid 4 cycles after accept.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode/state enums and flag constants shared by the multi-cycle ALU.
// The optional iterative multiplier is built only when ALU_MC_MUL_EN is defined.
package alu_mc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned NZP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 3'b000,
    ALU_AND   = 3'b001,
    ALU_XOR   = 3'b010,
    ALU_PASSA = 3'b011,
    ALU_LSHF  = 3'b100,
    ALU_RSHFL = 3'b101,
    ALU_RSHFA = 3'b110,
    ALU_MUL   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [NZP_W-1:0] NZP_N = 3'b100;
  localparam logic [NZP_W-1:0] NZP_Z = 3'b010;
  localparam logic [NZP_W-1:0] NZP_P = 3'b001;

  // Condition codes from the result sign bit and its zero test
  function automatic logic [NZP_W-1:0] nzp_calc(input logic i_neg, input logic i_zero);
    logic [NZP_W-1:0] v;
    if (i_zero) begin
      v = NZP_Z;
    end else if (i_neg) begin
      v = NZP_N;
    end else begin
      v = NZP_P;
    end
    return v;
  endfunction

  // True for the three LC-3b shift opcodes
  function automatic logic is_shift(input alu_op_e i_op);
    return (i_op == ALU_LSHF) || (i_op == ALU_RSHFL) || (i_op == ALU_RSHFA);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative datapath for the multi-cycle ops. Shifts move one bit
// position per step; with ALU_MC_MUL_EN defined, MUL does one shift-add step per
// multiplier bit. o_next_c is the value the current step produces, so the
// caller can capture the final result on the same edge as the last step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_next_c
);

  logic [WIDTH-1:0] r_val;
  alu_op_e          r_kind;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_next;
  logic             w_active;

  assign w_active = i_step && (r_cnt != '0);

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  // Multiplicand walks left and multiplier walks right, one bit per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (w_active) begin
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`else
  logic w_unused_b;
  assign w_unused_b = ^i_b;
`endif

  // Value produced by one step of the captured operation
  always_comb begin
    w_next = r_val;
    case (r_kind)
      ALU_LSHF:  w_next = {r_val[WIDTH-2:0], 1'b0};
      ALU_RSHFL: w_next = {1'b0, r_val[WIDTH-1:1]};
      ALU_RSHFA: w_next = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
`ifdef ALU_MC_MUL_EN
      ALU_MUL:   w_next = r_val + (r_mplier[0] ? r_mcand : '0);
`endif
      default:   w_next = r_val;
    endcase
  end

  // Operand/accumulator and remaining-step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val  <= '0;
      r_kind <= ALU_ADD;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_val  <= (i_op == ALU_MUL) ? '0 : i_a;
      r_kind <= i_op;
      r_cnt  <= i_cnt;
    end else if (w_active) begin
      r_val  <= w_next;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == CNT_W'(1));
  assign o_next_c = w_next;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle LC-3b ALU with valid/ready handshake and NZP/overflow flags.
// Single-cycle ops and zero-amount shifts finish in one cycle; other shifts and
// MUL run in alu_mc_iter. Define ALU_MC_MUL_EN to build the multiplier; without
// it op 111 completes in one cycle with result 0 and illegal set.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MSB   = WIDTH - 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_nzp;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [2:0]       w_nzp_nxt;
  logic             w_ovf_nxt;
  logic             w_illegal_nxt;

  alu_op_e            w_op;
  logic               w_accept;
  logic               w_multi;
  logic [SHAMT_W-1:0] w_shamt;
  logic [CNT_W-1:0]   w_amt;
  logic [CNT_W-1:0]   w_iter_cnt;
  logic               w_iter_load;
  logic               w_iter_step;
  logic               w_iter_last;
  logic [WIDTH-1:0]   w_iter_next;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_ill;

  assign w_op     = alu_op_e'(op);
  assign w_accept = in_valid && r_in_ready;

  // Shift amount from the low bits of b, saturated at WIDTH
  assign w_shamt = b[SHAMT_W-1:0];
  assign w_amt   = (CNT_W'(w_shamt) >= CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(w_shamt);

`ifdef ALU_MC_MUL_EN
  assign w_multi = (w_op == ALU_MUL) || (is_shift(w_op) && (w_amt != '0));
`else
  assign w_multi = is_shift(w_op) && (w_amt != '0);
`endif

  assign w_iter_cnt  = (w_op == ALU_MUL) ? CNT_W'(WIDTH) : w_amt;
  assign w_iter_load = (r_state == S_IDLE) && w_accept && w_multi;
  assign w_iter_step = (r_state == S_BUSY);

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_iter_load),
    .i_step   (w_iter_step),
    .i_op     (w_op),
    .i_a      (a),
    .i_b      (b),
    .i_cnt    (w_iter_cnt),
    .o_last_c (w_iter_last),
    .o_next_c (w_iter_next)
  );

  // Single-cycle result and flags from the presented operands
  always_comb begin
    w_sum     = a + b;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (w_op)
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      ALU_AND:   w_alu_res = a & b;
      ALU_XOR:   w_alu_res = a ^ b;
      ALU_PASSA: w_alu_res = a;
      ALU_LSHF, ALU_RSHFL, ALU_RSHFA: w_alu_res = a;
      ALU_MUL: begin
        w_alu_res = '0;
`ifndef ALU_MC_MUL_EN
        w_alu_ill = 1'b1;
`endif
      end
      default:   w_alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_multi ? S_BUSY : S_DONE;
      S_BUSY: if (w_iter_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values; result and flags change only when an op completes
  always_comb begin
    w_result_nxt    = r_result;
    w_nzp_nxt       = r_nzp;
    w_ovf_nxt       = r_ovf;
    w_illegal_nxt   = r_illegal;
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_multi) begin
          w_result_nxt  = w_alu_res;
          w_nzp_nxt     = nzp_calc(w_alu_res[MSB], w_alu_res == '0);
          w_ovf_nxt     = w_alu_ovf;
          w_illegal_nxt = w_alu_ill;
        end
      end
      S_BUSY: begin
        if (w_iter_last) begin
          w_result_nxt  = w_iter_next;
          w_nzp_nxt     = nzp_calc(w_iter_next[MSB], w_iter_next == '0);
          w_ovf_nxt     = 1'b0;
          w_illegal_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nzp       <= NZP_Z;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_nzp       <= w_nzp_nxt;
      r_ovf       <= w_ovf_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign nzp       = r_nzp;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

endmodule
